// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the RAM port arbiter: FSM states, owner,
// access-length codes and bus widths.
package mem_arbiter_pkg;

  localparam int INST_ADDR_W = 32;  // instruction address bus width
  localparam int INST_W      = 32;  // instruction / data bus width
  localparam int BYTE_W      = 8;   // RAM port width

  typedef enum logic [1:0] {
    ArbIdle,
    ArbRd,
    ArbWr,
    ArbFin
  } arb_state_t;

  typedef enum logic {
    OwnerIf,
    OwnerMem
  } owner_t;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  // Byte count of an access; the reserved code 11 behaves as a word.
  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store, RAM and stall signals around the arbiter.
// slave = arbiter side, master = pipeline + RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  import mem_arbiter_pkg::*;

  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic [INST_W-1:0]     if_data;
  logic                  if_done;
  logic                  br;

  logic                  mem_req;
  logic                  mem_we;
  logic [1:0]            mem_len;
  logic [ADDR_W-1:0]     mem_addr;
  logic [INST_W-1:0]     mem_wdata;
  logic [INST_W-1:0]     mem_rdata;
  logic                  mem_done;

  logic [ADDR_W-1:0]     ram_addr;
  logic                  ram_wr;
  logic [BYTE_W-1:0]     ram_dout;
  logic [BYTE_W-1:0]     ram_din;

  logic                  stall;

  modport slave (
    input  if_req, if_addr, br, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    output if_data, if_done, mem_rdata, mem_done, ram_addr, ram_wr, ram_dout, stall
  );

  modport master (
    output if_req, if_addr, br, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    input  if_data, if_done, mem_rdata, mem_done, ram_addr, ram_wr, ram_dout, stall
  );

endinterface

// File: rtl/mem_arbiter_byte_seq.sv
// Byte sequencer: latches base/count/store data on load, steps a byte
// counter, forms base+cnt, selects the outgoing store byte and assembles
// incoming read bytes little-endian into a zero-filled word.
module mem_arbiter_byte_seq
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [2:0]        n_in,
  input  logic [INST_W-1:0] wdata_in,
  input  logic              step,
  input  logic              capture,
  input  logic [BYTE_W-1:0] ram_din,
  output logic [2:0]        cnt,
  output logic [2:0]        n,
  output logic [ADDR_W-1:0] addr,
  output logic [BYTE_W-1:0] wbyte,
  output logic [INST_W-1:0] data
);

  logic [ADDR_W-1:0] base;
  logic [INST_W-1:0] wdata;
  logic [1:0]        cap_lane;

  // The byte arriving now was addressed one cycle ago, so it belongs to lane cnt-1.
  assign cap_lane = cnt[1:0] - 2'd1;
  assign addr     = base + ADDR_W'(cnt);
  assign wbyte    = wdata[{cnt[1:0], 3'b000} +: BYTE_W];

  // Sequencer registers: reload on grant, otherwise count and capture.
  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      n     <= '0;
      base  <= '0;
      wdata <= '0;
      data  <= '0;
    end else if (load) begin
      cnt   <= '0;
      n     <= n_in;
      base  <= base_in;
      wdata <= wdata_in;
      data  <= '0;  // unused upper bytes must read back as zero
    end else begin
      if (step)    cnt <= cnt + 3'd1;
      if (capture) data[{cap_lane, 3'b000} +: BYTE_W] <= ram_din;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single 8-bit RAM port shared by instruction fetch and
// load/store. MEM has priority; each access runs as N byte transfers and
// ends with a one-cycle done pulse. A branch aborts a fetch in flight.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  arb_state_t        state, state_nxt;
  owner_t            owner, owner_nxt;

  logic              load, step, capture;
  logic [ADDR_W-1:0] seq_base;
  logic [2:0]        seq_n;
  logic [INST_W-1:0] seq_wdata;
  logic [2:0]        cnt, n;
  logic [ADDR_W-1:0] seq_addr;
  logic [BYTE_W-1:0] seq_wbyte;
  logic [INST_W-1:0] seq_data;
  logic              if_flush;

  assign if_flush = bus.br && (owner == OwnerIf);

  mem_arbiter_byte_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .base_in  (seq_base),
    .n_in     (seq_n),
    .wdata_in (seq_wdata),
    .step     (step),
    .capture  (capture),
    .ram_din  (bus.ram_din),
    .cnt      (cnt),
    .n        (n),
    .addr     (seq_addr),
    .wbyte    (seq_wbyte),
    .data     (seq_data)
  );

  // State and owner registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ArbIdle;
      owner <= OwnerIf;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // Next state, arbitration and sequencer control.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    load      = 1'b0;
    step      = 1'b0;
    capture   = 1'b0;
    seq_base  = bus.mem_addr;
    seq_n     = len_to_n(bus.mem_len);
    seq_wdata = bus.mem_wdata;
    case (state)
      ArbIdle: begin
        if (bus.mem_req) begin
          load      = 1'b1;
          owner_nxt = OwnerMem;
          state_nxt = bus.mem_we ? ArbWr : ArbRd;
        end else if (bus.if_req && !bus.br) begin
          load      = 1'b1;
          owner_nxt = OwnerIf;
          seq_base  = bus.if_addr;
          seq_n     = 3'd4;
          seq_wdata = '0;
          state_nxt = ArbRd;
        end
      end
      ArbRd: begin
        if (if_flush) begin
          state_nxt = ArbIdle;
        end else begin
          capture = (cnt != 3'd0);
          if (cnt == n) state_nxt = ArbFin;
          else          step      = 1'b1;
        end
      end
      ArbWr: begin
        step = 1'b1;
        if (cnt == n - 3'd1) state_nxt = ArbFin;
      end
      ArbFin:  state_nxt = ArbIdle;  // requests ignored for one cycle
      default: state_nxt = ArbIdle;
    endcase
  end

  // RAM port and completion outputs, all zero outside their active state.
  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_wr    = 1'b0;
    bus.ram_dout  = '0;
    bus.if_done   = 1'b0;
    bus.if_data   = '0;
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    case (state)
      ArbRd: begin
        if (cnt != n) bus.ram_addr = seq_addr;
      end
      ArbWr: begin
        bus.ram_wr   = 1'b1;
        bus.ram_addr = seq_addr;
        bus.ram_dout = seq_wbyte;
      end
      ArbFin: begin
        if (owner == OwnerMem) begin
          bus.mem_done  = 1'b1;
          bus.mem_rdata = seq_data;
        end else if (!bus.br) begin
          bus.if_done = 1'b1;
          bus.if_data = seq_data;
        end
      end
      default: ;
    endcase
  end

  assign bus.stall = (bus.if_req & ~bus.if_done & ~bus.br) | (bus.mem_req & ~bus.mem_done);

endmodule
